// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Groups the instruction-memory request/grant/response channel, the
//   decode valid/ready channel and the execute redirect inputs of the
//   fetch stage into one bundle.
//   master : fetch stage side
//            (drives imem_req/imem_addr, instr_valid/instr/instr_pc, fetch_fault)
//   slave  : environment side
//            (drives imem_gnt/imem_rvalid/imem_rdata, instr_ready, redirect/redirect_pc)
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Holds the fetch PC, issues word requests to
//   instruction memory, tags each granted request with its PC, buffers the
//   returned words in a BUF_DEPTH-entry FIFO and presents them to decode.
//   A redirect from execute reloads the PC, flushes the FIFO and turns every
//   outstanding response into one that will be dropped on arrival.
//
//   Ports
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : fetch_unit_if.master (imem request/response, decode handshake,
//             redirect inputs, fetch_fault)
//
//   Optional feature macro: FETCH_MISALIGN_CHECK_EN
//     defined   : a redirect to a non word-aligned target parks the stage in
//                 FAULT with fetch_fault=1 until an aligned redirect arrives.
//     undefined : redirect_pc[1:0] is ignored, fetch_fault is tied to 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;   // holds 0..BUF_DEPTH
  localparam int DW = CW + 4;   // discard may accumulate across back-to-back redirects

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    FAULT = 2'd2
`endif
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   fifo_data [BUF_DEPTH];
  logic [31:0]   fifo_pc   [BUF_DEPTH];
  logic [31:0]   tag_pc    [BUF_DEPTH];
  logic [PW-1:0] fifo_wr_ptr_reg, fifo_rd_ptr_reg;
  logic [PW-1:0] tag_wr_ptr_reg, tag_rd_ptr_reg;
  logic [CW-1:0] fifo_count_reg, pending_reg;
  logic [DW-1:0] discard_reg;

  logic          imem_req_c;
  logic          credit_ok;
  logic          grant, resp_keep, resp_drop, resp_any, pop;
  logic          instr_valid_c;
  logic [31:0]   redirect_target;
  logic          misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_target = bus.redirect_pc;
  assign misaligned      = bus.redirect_pc[1:0] != 2'b00;
`else
  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign misaligned      = 1'b0;
`endif

  // Credits count both buffered words and words still owed by memory, so a
  // response always finds a free FIFO slot.
  assign credit_ok = ({1'b0, fifo_count_reg} + {1'b0, pending_reg}) < (CW+1)'(BUF_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    imem_req_c = 1'b0;
    case (state_reg)
      IDLE:    state_next = RUN;
      RUN:     imem_req_c = !bus.redirect && credit_ok;
`ifdef FETCH_MISALIGN_CHECK_EN
      FAULT:   state_next = FAULT;
`endif
      default: state_next = IDLE;
    endcase
    if (bus.redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      state_next = misaligned ? FAULT : RUN;
`else
      state_next = RUN;
`endif
    end
  end

  assign instr_valid_c = fifo_count_reg != '0;
  assign grant     = imem_req_c && bus.imem_gnt;
  assign resp_drop = bus.imem_rvalid && (discard_reg != '0);
  // A response with nothing pending and nothing to discard is ignored.
  assign resp_keep = bus.imem_rvalid && (discard_reg == '0) && (pending_reg != '0);
  assign resp_any  = resp_drop || resp_keep;
  assign pop       = instr_valid_c && bus.instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
      fifo_count_reg  <= '0;
      pending_reg     <= '0;
      discard_reg     <= '0;
    end else if (bus.redirect) begin
      // Flush wins over everything; a head pop this cycle is simply absorbed
      // by the flush. Every in-flight response becomes a discard, less the
      // one (if any) that is being dropped right now.
      fetch_pc_reg    <= redirect_target;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
      fifo_count_reg  <= '0;
      pending_reg     <= '0;
      discard_reg     <= discard_reg + DW'(pending_reg) - DW'(resp_any);
    end else begin
      if (grant) begin
        fetch_pc_reg   <= fetch_pc_reg + 32'd4;
        tag_wr_ptr_reg <= tag_wr_ptr_reg + 1'b1;
      end
      if (resp_keep) begin
        fifo_wr_ptr_reg <= fifo_wr_ptr_reg + 1'b1;
        tag_rd_ptr_reg  <= tag_rd_ptr_reg + 1'b1;
      end
      if (pop) fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 1'b1;
      if (resp_drop) discard_reg <= discard_reg - 1'b1;
      pending_reg    <= pending_reg + CW'(grant) - CW'(resp_keep);
      fifo_count_reg <= fifo_count_reg + CW'(resp_keep) - CW'(pop);
    end
  end

  // Storage arrays carry no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (grant) tag_pc[tag_wr_ptr_reg] <= fetch_pc_reg;
    if (resp_keep && !bus.redirect) begin
      fifo_data[fifo_wr_ptr_reg] <= bus.imem_rdata;
      fifo_pc[fifo_wr_ptr_reg]   <= tag_pc[tag_rd_ptr_reg];
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_fault_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_fault_reg <= 1'b0;
    else        fetch_fault_reg <= (state_next == FAULT);
  end
  assign bus.fetch_fault = fetch_fault_reg;
`else
  assign bus.fetch_fault = misaligned;
`endif

  assign bus.imem_req    = imem_req_c;
  assign bus.imem_addr   = fetch_pc_reg;
  assign bus.instr_valid = instr_valid_c;
  assign bus.instr       = instr_valid_c ? fifo_data[fifo_rd_ptr_reg] : 32'h0;
  assign bus.instr_pc    = instr_valid_c ? fifo_pc[fifo_rd_ptr_reg]   : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit. Instance a uses RESET_PC=0 and a memory
//   model with programmable grant and response latency; instance b uses
//   RESET_PC=32'hFFFF_FFF8 with always-grant, 1-cycle memory.
//   Memory returns word = address ^ 32'hDEAD_0000.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if ifa ();
  fetch_unit_if ifb ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] grants_a[$], cons_pc[$], cons_instr[$];
  logic [31:0] grants_b[$], cons_b[$];

  logic        s_req, s_valid, s_fault;
  logic [31:0] s_addr, s_instr, s_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // One clock: sample both DUTs mid-cycle, log handshakes, advance, then
  // update the memory models for the new cycle.
  task automatic tick();
    logic fire_a, fire_b;
    logic [31:0] addr_a, addr_b;
    #1;
    s_req = ifa.imem_req; s_addr = ifa.imem_addr; s_valid = ifa.instr_valid;
    s_instr = ifa.instr; s_pc = ifa.instr_pc; s_fault = ifa.fetch_fault;
    fire_a = ifa.imem_req && ifa.imem_gnt; addr_a = ifa.imem_addr;
    fire_b = ifb.imem_req && ifb.imem_gnt; addr_b = ifb.imem_addr;
    if (fire_a) grants_a.push_back(addr_a);
    if (fire_b) grants_b.push_back(addr_b);
    if (ifa.instr_valid && ifa.instr_ready) begin
      cons_pc.push_back(ifa.instr_pc);
      cons_instr.push_back(ifa.instr);
    end
    if (ifb.instr_valid && ifb.instr_ready) cons_b.push_back(ifb.instr_pc);
    @(posedge clk); #1;
    if (fire_a) begin
      mq_addr.push_back(addr_a);
      mq_due.push_back(cyc + lat);
    end
    cyc++;
    ifa.imem_rvalid = 1'b0;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      ifa.imem_rvalid = 1'b1;
      ifa.imem_rdata  = word_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    ifb.imem_rvalid = fire_b;
    ifb.imem_rdata  = word_of(addr_b);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ifa.redirect = 1'b0; ifa.redirect_pc = 32'h0; ifa.instr_ready = 1'b1;
    ifa.imem_gnt = 1'b1; ifa.imem_rvalid = 1'b0; ifa.imem_rdata = 32'h0;
    ifb.redirect = 1'b0; ifb.redirect_pc = 32'h0; ifb.instr_ready = 1'b1;
    ifb.imem_gnt = 1'b1; ifb.imem_rvalid = 1'b0; ifb.imem_rdata = 32'h0;
    lat = 1;
    mq_addr.delete(); mq_due.delete();
    grants_a.delete(); cons_pc.delete(); cons_instr.delete();
    grants_b.delete(); cons_b.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ifa.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", ifa.imem_req); end
    checks++; if (ifa.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 00000000", ifa.imem_addr); end
    checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ifa.instr_valid); end
    checks++; if (ifa.instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 00000000", ifa.instr); end
    checks++; if (ifa.instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 00000000", ifa.instr_pc); end
    checks++; if (ifa.fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", ifa.fetch_fault); end
    checks++; if (ifb.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL rst_addr_b: got %h expected fffffff8", ifb.imem_addr); end
    apply_reset();
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", s_req); end
    $display("test_reset done, cycle %0d", cyc);
  endtask

  task automatic test_stream();
    apply_reset();
    tick(); // cycle 0: IDLE
    tick(); // cycle 1
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL c1_req: got req=%b addr=%h expected req=1 addr=00000000", s_req, s_addr); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL c1_valid: got %b expected 0", s_valid); end
    tick(); // cycle 2
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h4) begin errors++; $display("FAIL c2_req: got req=%b addr=%h expected req=1 addr=00000004", s_req, s_addr); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL c2_valid: got %b expected 0", s_valid); end
    tick(); // cycle 3: first instruction visible, credits exhausted
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== 32'hDEAD_0000) begin errors++; $display("FAIL c3_head: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=dead0000", s_valid, s_pc, s_instr); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL c3_credit: got req=%b expected 0", s_req); end
    repeat (16) tick();
    for (int i = 0; i < grants_a.size(); i++) begin
      checks++; if (grants_a[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, grants_a[i], 32'(4 * i)); end
    end
    checks++; if (cons_pc.size() < 6) begin errors++; $display("FAIL stream_count: got %0d expected >=6", cons_pc.size()); end
    for (int i = 0; i < cons_pc.size(); i++) begin
      checks++; if (cons_pc[i] !== 32'(4 * i) || cons_instr[i] !== word_of(32'(4 * i))) begin errors++; $display("FAIL stream_instr[%0d]: got pc=%h instr=%h expected pc=%h", i, cons_pc[i], cons_instr[i], 32'(4 * i)); end
    end
    $display("test_stream done: %0d grants, %0d instructions", grants_a.size(), cons_pc.size());
  endtask

  task automatic test_backpressure();
    apply_reset();
    ifa.instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (grants_a.size() - cons_pc.size() > 2) begin errors++; $display("FAIL bp_credit[%0d]: got %0d outstanding expected <=2", i, grants_a.size() - cons_pc.size()); end
    end
    checks++; if (s_req !== 1'b0 || s_valid !== 1'b1) begin errors++; $display("FAIL bp_stall: got req=%b valid=%b expected req=0 valid=1", s_req, s_valid); end
    checks++; if (grants_a.size() != 2) begin errors++; $display("FAIL bp_grants: got %0d expected 2", grants_a.size()); end
    ifa.instr_ready = 1'b1;
    repeat (20) tick();
    checks++; if (cons_pc.size() < 6) begin errors++; $display("FAIL bp_resume: got %0d instructions expected >=6", cons_pc.size()); end
    for (int i = 0; i < cons_pc.size(); i++) begin
      checks++; if (cons_pc[i] !== 32'(4 * i) || cons_instr[i] !== word_of(32'(4 * i))) begin errors++; $display("FAIL bp_seq[%0d]: got pc=%h instr=%h expected pc=%h", i, cons_pc[i], cons_instr[i], 32'(4 * i)); end
    end
    $display("test_backpressure done: %0d instructions", cons_pc.size());
  endtask

  task automatic test_redirect_flush();
    apply_reset();
    lat = 3;
    tick(); tick(); tick(); // cycles 0..2: two requests granted
    ifa.redirect = 1'b1; ifa.redirect_pc = 32'h100;
    tick(); // cycle 3: redirect
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rf_req: got %b expected 0", s_req); end
    ifa.redirect = 1'b0;
    tick(); // cycle 4
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL rf_addr: got req=%b addr=%h expected req=1 addr=00000100", s_req, s_addr); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %b expected 0", s_valid); end
    for (int i = 0; i < 30 && cons_pc.size() == 0; i++) tick();
    checks++;
    if (cons_pc.size() == 0) begin errors++; $display("FAIL rf_timeout: got no instruction expected pc=00000100"); end
    else if (cons_pc[0] !== 32'h100 || cons_instr[0] !== word_of(32'h100)) begin errors++; $display("FAIL rf_first: got pc=%h instr=%h expected pc=00000100 instr=%h", cons_pc[0], cons_instr[0], word_of(32'h100)); end
    $display("test_redirect_flush done, cycle %0d", cyc);
  endtask

  task automatic test_redirect_handshake();
    apply_reset();
    ifa.instr_ready = 1'b0;
    tick(); tick(); tick(); // cycles 0..2
    ifa.instr_ready = 1'b1; ifa.redirect = 1'b1; ifa.redirect_pc = 32'h40;
    tick(); // cycle 3: head pop, response for 0x4, redirect together
    ifa.redirect = 1'b0;
    tick(); // cycle 4
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rh_empty: got valid=%b expected 0", s_valid); end
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h40) begin errors++; $display("FAIL rh_addr: got req=%b addr=%h expected req=1 addr=00000040", s_req, s_addr); end
    checks++; if (cons_pc.size() != 1 || cons_pc[0] !== 32'h0) begin errors++; $display("FAIL rh_once: got %0d pops expected 1 of pc=00000000", cons_pc.size()); end
    for (int i = 0; i < 30 && cons_pc.size() < 2; i++) tick();
    checks++;
    if (cons_pc.size() < 2) begin errors++; $display("FAIL rh_timeout: got %0d instructions expected 2", cons_pc.size()); end
    else if (cons_pc[1] !== 32'h40 || cons_instr[1] !== word_of(32'h40)) begin errors++; $display("FAIL rh_next: got pc=%h instr=%h expected pc=00000040", cons_pc[1], cons_instr[1]); end
    $display("test_redirect_handshake done, cycle %0d", cyc);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_b [3];
    exp_b[0] = 32'hFFFF_FFF8; exp_b[1] = 32'hFFFF_FFFC; exp_b[2] = 32'h0000_0000;
    apply_reset();
    repeat (8) tick();
    checks++; if (grants_b.size() < 3) begin errors++; $display("FAIL wrap_count: got %0d grants expected >=3", grants_b.size()); end
    for (int i = 0; i < 3 && i < grants_b.size(); i++) begin
      checks++; if (grants_b[i] !== exp_b[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, grants_b[i], exp_b[i]); end
    end
    checks++; if (cons_b.size() == 0 || cons_b[0] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pc: got %0d instructions expected first pc=fffffff8", cons_b.size()); end
    $display("test_wrap done: %0d grants", grants_b.size());
  endtask

  task automatic test_misalign();
    apply_reset();
    repeat (6) tick();
    ifa.redirect = 1'b1; ifa.redirect_pc = 32'h102;
    tick();
    ifa.redirect = 1'b0;
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if (s_fault !== 1'b1) begin errors++; $display("FAIL ma_fault: got %b expected 1", s_fault); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL ma_req0: got %b expected 0", s_req); end
    tick(); tick();
    checks++; if (s_req !== 1'b0 || s_fault !== 1'b1) begin errors++; $display("FAIL ma_hold: got req=%b fault=%b expected req=0 fault=1", s_req, s_fault); end
`else
    checks++; if (s_fault !== 1'b0) begin errors++; $display("FAIL ma_fault: got %b expected 0", s_fault); end
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL ma_align: got req=%b addr=%h expected req=1 addr=00000100", s_req, s_addr); end
    tick(); tick();
`endif
    ifa.redirect = 1'b1; ifa.redirect_pc = 32'h200;
    tick();
    ifa.redirect = 1'b0;
    tick();
    checks++; if (s_fault !== 1'b0) begin errors++; $display("FAIL ma_clear: got %b expected 0", s_fault); end
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin errors++; $display("FAIL ma_resume: got req=%b addr=%h expected req=1 addr=00000200", s_req, s_addr); end
    $display("test_misalign done, cycle %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_handshake();
    test_wrap();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
